// File: rtl/sift_stage_sequencer.sv
// Run controller for the SIFT core: steps the blur, detect/filter and
// descriptor/match engines through start/done handshakes, guards each stage
// with a watchdog, latches keypoint counts and emits a run or error report.
module sift_stage_sequencer #(
  parameter int unsigned          TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = TIMEOUT_W'(24'hFFFFFF),
  parameter int unsigned          KPT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             abort,
  input  logic             gauss_done,
  input  logic             detect_done,
  input  logic             match_done,
  input  logic [KPT_W-1:0] kpt_cnt_1,
  input  logic [KPT_W-1:0] kpt_cnt_2,
  output logic             gauss_start,
  output logic             detect_start,
  output logic             match_start,
  output logic [2:0]       stage_sel,
  output logic [KPT_W-1:0] kpt_num_1,
  output logic [KPT_W-1:0] kpt_num_2,
  output logic             busy,
  output logic             err,
  output logic             out_valid,
  output logic [15:0]      out_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAUSS  = 3'd1,
    ST_DETECT = 3'd2,
    ST_MATCH  = 3'd3,
    ST_REPORT = 3'd4,
    ST_END    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Last watchdog value a stage may spend without its done pulse.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT - TIMEOUT_W'(1);

  state_t               state, next_state;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [31:0]          cyc_cnt;
  logic [1:0]           rpt_idx, rpt_idx_nxt;
  logic                 run_stage;
  logic                 wd_expired;
  logic                 start_run;

  logic                 gauss_start_d, detect_start_d, match_start_d;
  logic                 busy_d, err_d, out_valid_d;
  logic [15:0]          out_data_d;

  assign run_stage   = state inside {ST_GAUSS, ST_DETECT, ST_MATCH};
  assign wd_expired  = (wd_cnt == WD_LAST);
  assign start_run   = (state inside {ST_IDLE, ST_END, ST_ERR}) && in_valid;
  assign rpt_idx_nxt = (state == ST_REPORT) ? rpt_idx + 2'd1 : 2'd0;
  assign stage_sel   = state;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: abort outranks done, done outranks watchdog expiry.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_END, ST_ERR: if (in_valid) next_state = ST_GAUSS;
      ST_GAUSS: begin
        if      (abort)       next_state = ST_IDLE;
        else if (gauss_done)  next_state = ST_DETECT;
        else if (wd_expired)  next_state = ST_ERR;
      end
      ST_DETECT: begin
        if      (abort)       next_state = ST_IDLE;
        else if (detect_done) next_state = ST_MATCH;
        else if (wd_expired)  next_state = ST_ERR;
      end
      ST_MATCH: begin
        if      (abort)       next_state = ST_IDLE;
        else if (match_done)  next_state = ST_REPORT;
        else if (wd_expired)  next_state = ST_ERR;
      end
      ST_REPORT: begin
        if      (abort)            next_state = ST_IDLE;
        else if (rpt_idx == 2'd3)  next_state = ST_END;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up
  // with the state they describe.
  always_comb begin
    gauss_start_d  = (next_state == ST_GAUSS);
    detect_start_d = (next_state == ST_DETECT);
    match_start_d  = (next_state == ST_MATCH);
    busy_d         = next_state inside {ST_GAUSS, ST_DETECT, ST_MATCH, ST_REPORT};
    err_d          = (next_state == ST_ERR);
    out_valid_d    = 1'b0;
    out_data_d     = '0;
    if (next_state == ST_REPORT) begin
      out_valid_d = 1'b1;
      unique case (rpt_idx_nxt)
        2'd0: out_data_d = 16'(kpt_num_1);
        2'd1: out_data_d = 16'(kpt_num_2);
        2'd2: out_data_d = cyc_cnt[31:16];
        2'd3: out_data_d = cyc_cnt[15:0];
      endcase
    end else if (next_state == ST_ERR && state != ST_ERR) begin
      out_valid_d = 1'b1;
      out_data_d  = 16'hE000 | {13'b0, state};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gauss_start  <= 1'b0;
      detect_start <= 1'b0;
      match_start  <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else begin
      gauss_start  <= gauss_start_d;
      detect_start <= detect_start_d;
      match_start  <= match_start_d;
      busy         <= busy_d;
      err          <= err_d;
      out_valid    <= out_valid_d;
      out_data     <= out_data_d;
    end
  end

  // Watchdog, run cycle counter, report index and keypoint count latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      cyc_cnt   <= '0;
      rpt_idx   <= '0;
      kpt_num_1 <= '0;
      kpt_num_2 <= '0;
    end else begin
      rpt_idx <= rpt_idx_nxt;

      if (next_state != state) wd_cnt <= '0;
      else if (run_stage)      wd_cnt <= wd_cnt + TIMEOUT_W'(1);

      if (start_run)                         cyc_cnt <= '0;
      else if (run_stage && cyc_cnt != '1)   cyc_cnt <= cyc_cnt + 32'd1;

      if (start_run) begin
        kpt_num_1 <= '0;
        kpt_num_2 <= '0;
      end else if (state == ST_DETECT && next_state == ST_MATCH) begin
        kpt_num_1 <= kpt_cnt_1;
        kpt_num_2 <= kpt_cnt_2;
      end
    end
  end

endmodule

// File: doc/sift_stage_sequencer.md
Name: sift_stage_sequencer

Overview:
Top-level run controller for the SIFT core. It sequences the Gaussian-blur, keypoint detect/filter and descriptor/match engines through start/done handshakes. It drives the stage-select code used by the shared blur/image/keypoint SRAM address muxes and latches keypoint counts at the end of detection. It guards each stage with a timeout and emits a 4-word run report (or a 1-word error report) on out_valid/out_data.

Parameters:
TIMEOUT_W, 24, width of the per-stage watchdog counter
TIMEOUT, 24'hFFFFFF, maximum cycles allowed in any one stage before error
KPT_W, 11, width of keypoint count inputs/outputs

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  run start request, level-sampled
abort  in  1  cancel current run
gauss_done  in  1  Gaussian engine done pulse
detect_done  in  1  detect/filter engine done pulse
match_done  in  1  descriptor/match engine done pulse
kpt_cnt_1  in  KPT_W  layer-1 keypoint write address from detect engine
kpt_cnt_2  in  KPT_W  layer-2 keypoint write address from detect engine
gauss_start  out  1  high while in GAUSS
detect_start  out  1  high while in DETECT
match_start  out  1  high while in MATCH
stage_sel  out  3  current state code, drives SRAM muxes
kpt_num_1  out  KPT_W  latched layer-1 keypoint count
kpt_num_2  out  KPT_W  latched layer-2 keypoint count
busy  out  1  high in GAUSS, DETECT, MATCH, REPORT
err  out  1  high in ERR
out_valid  out  1  report word valid
out_data  out  16  report word

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous active-low. All registers clear on reset: state=IDLE, all outputs 0.
- State codes: IDLE=0, GAUSS=1, DETECT=2, MATCH=3, REPORT=4, END=5, ERR=6. stage_sel equals the state register.
- Stage starts are registered decodes of the state, so each is high exactly while in its state.
- Transitions:
  - IDLE, END, ERR: in_valid=1 -> GAUSS next cycle. On this transition, clear the cycle counter, watchdog, kpt_num_1/2 and err.
  - GAUSS: gauss_done -> DETECT.
  - DETECT: detect_done -> MATCH. In the same cycle, kpt_num_1<=kpt_cnt_1 and kpt_num_2<=kpt_cnt_2.
  - MATCH: match_done -> REPORT.
  - REPORT: runs 4 cycles (2-bit index 0..3), then END.
- Done inputs are honoured only in their own stage. A done for any other stage is ignored.
- in_valid while busy is ignored.
- Watchdog:
  - Clears on every stage entry and increments each cycle in GAUSS, DETECT or MATCH.
  - If the counter reaches TIMEOUT-1 and the stage's done is low -> ERR.
  - Done and timeout in the same cycle: done wins.
- abort=1 in GAUSS, DETECT, MATCH or REPORT -> IDLE next cycle.
  - All starts drop, no report is produced, out_valid is forced 0.
  - abort outranks done and timeout.
  - abort in IDLE, END or ERR has no effect.
- Run cycle counter (32 bit):
  - Counts every cycle spent in GAUSS, DETECT and MATCH, inclusive.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value in REPORT, END and ERR.
- Report (out_valid=1 for exactly 4 consecutive cycles, no backpressure):
  - word0 = zero-extended kpt_num_1
  - word1 = zero-extended kpt_num_2
  - word2 = cyc[31:16]
  - word3 = cyc[15:0]
  - Output is registered: word k appears in the cycle where the REPORT index equals k.
- ERR entry:
  - out_valid=1 for one cycle with out_data = 16'hE000 | {13'b0, failing state code}.
  - err stays high until restart.
- out_data=0 whenever out_valid=0.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No report.

Test Plan:
1. Nominal run: in_valid 1 cycle; gauss_done after 10 cycles in GAUSS; detect_done after 5 cycles in DETECT with kpt_cnt_1=11'd37, kpt_cnt_2=11'd12; match_done after 3 cycles in MATCH -> stage_sel walks 1,2,3,4,5; report words 0x0025, 0x000C, 0x0000, 0x0012 (18 cycles); busy low in END.
2. Stray dones: pulse match_done and detect_done during GAUSS -> state stays 1; kpt_num unchanged (0).
3. Timeout: TIMEOUT=16, never assert detect_done -> ERR 16 cycles after DETECT entry; single word 0xE002; err=1; detect_start=0.
4. Done and timeout coincident in GAUSS (TIMEOUT=16, gauss_done on 16th cycle) -> DETECT, no error word.
5. Abort and done in the same MATCH cycle -> IDLE; no out_valid; then in_valid restarts cleanly with kpt_num cleared to 0.
6. Async reset pulse mid-DETECT, not aligned to clk -> all outputs 0 immediately; after release, state remains IDLE until in_valid.
